// File: rtl/cam_pwr_pkg.sv
// Shared types and constants for the multi-camera power-up sequencer.
//   ch_state_e   : per-channel sequencing state
//   DEF_*        : default timing set for a 100 MHz clock
//   cnt_width()  : delay-counter width from the longest interval
//   is_timed()   : states whose exit is paced by the ms tick
package cam_pwr_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_START = 3'd0,
    ST_PWUP       = 3'd1,
    ST_RSTW       = 3'd2,
    ST_CFGW       = 3'd3,
    ST_DONE       = 3'd4,
    ST_OFF        = 3'd5,
    ST_SLEEP      = 3'd6,
    ST_WAKE       = 3'd7
  } ch_state_e;

  localparam int unsigned DEF_N_CAM      = 2;
  localparam int unsigned DEF_TICK_CYC   = 100_000;
  localparam int unsigned DEF_T_PWUP_MS  = 10;
  localparam int unsigned DEF_T_RST_MS   = 10;
  localparam int unsigned DEF_T_CFG_MS   = 20;
  localparam int unsigned DEF_STAGGER_MS = 5;

  // Wide enough to hold the longest interval count without overflow.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

  function automatic logic is_timed(input ch_state_e s);
    return (s == ST_WAIT_START) || (s == ST_PWUP) || (s == ST_RSTW) ||
           (s == ST_CFGW) || (s == ST_WAKE);
  endfunction

endpackage

// File: rtl/cam_pwr_ch.sv
// One camera channel: sequencing FSM, ms delay counter, PWDN/RESET/ready flops.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   tick_i          : 1 ms prescaler tick
//   start_i         : (re)start the sequence; wins over any other event
//   en_i            : channel enable, taken when start_i is high
//   start_ticks_i   : stagger before power-up, in ticks
//   sleep_i         : sleep request (only with CAM_SLEEP_EN)
//   pwdn_o, rst_o   : camera power-down (1 = down) and reset (0 = held)
//   init_en_o       : channel ready for register configuration
//   state_o         : current state, used by the top for prescaler gating
module cam_pwr_ch
  import cam_pwr_pkg::*;
#(
  parameter int unsigned CW        = 4,
  parameter int unsigned T_PWUP_MS = DEF_T_PWUP_MS,
  parameter int unsigned T_RST_MS  = DEF_T_RST_MS,
  parameter int unsigned T_CFG_MS  = DEF_T_CFG_MS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick_i,
  input  logic          start_i,
  input  logic          en_i,
  input  logic [CW-1:0] start_ticks_i,
`ifdef CAM_SLEEP_EN
  input  logic          sleep_i,
`endif
  output logic          pwdn_o,
  output logic          rst_o,
  output logic          init_en_o,
  output ch_state_e     state_o
);

  ch_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic          pwdn_q;
  logic          rst_q;
  logic          init_q;
  logic [CW-1:0] last_c;

  // Terminal count for the interval of the current state.
  always_comb begin
    last_c = '0;
    case (state_q)
      ST_WAIT_START: last_c = start_ticks_i - CW'(1);
      ST_PWUP:       last_c = CW'(T_PWUP_MS - 1);
      ST_RSTW:       last_c = CW'(T_RST_MS - 1);
      ST_WAKE:       last_c = CW'(T_RST_MS - 1);
      ST_CFGW:       last_c = CW'(T_CFG_MS - 1);
      default:       last_c = '0;
    endcase
  end

  // Sequencing FSM; start has priority so a restart on a terminal tick wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      pwdn_q  <= 1'b1;
      rst_q   <= 1'b0;
      init_q  <= 1'b0;
    end else if (start_i) begin
      cnt_q  <= '0;
      pwdn_q <= 1'b1;
      rst_q  <= 1'b0;
      init_q <= 1'b0;
      if (!en_i)                   state_q <= ST_OFF;
      else if (start_ticks_i == '0) state_q <= ST_PWUP;
      else                          state_q <= ST_WAIT_START;
    end else if (is_timed(state_q) && tick_i) begin
      if (cnt_q == last_c) begin
        cnt_q <= '0;
        case (state_q)
          ST_WAIT_START: state_q <= ST_PWUP;
          ST_PWUP: begin
            state_q <= ST_RSTW;
            pwdn_q  <= 1'b0;
          end
          ST_RSTW: begin
            state_q <= ST_CFGW;
            rst_q   <= 1'b1;
          end
          ST_CFGW, ST_WAKE: begin
            state_q <= ST_DONE;
            init_q  <= 1'b1;
          end
          default: state_q <= state_q;
        endcase
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
`ifdef CAM_SLEEP_EN
    // Sleep keeps RESET released; wake only waits for the sensor to power back up.
    else if (state_q == ST_DONE && sleep_i) begin
      state_q <= ST_SLEEP;
      pwdn_q  <= 1'b1;
      init_q  <= 1'b0;
    end else if (state_q == ST_SLEEP && !sleep_i) begin
      state_q <= ST_WAKE;
      pwdn_q  <= 1'b0;
      cnt_q   <= '0;
    end
`endif
  end

  assign pwdn_o    = pwdn_q;
  assign rst_o     = rst_q;
  assign init_en_o = init_q;
  assign state_o   = state_q;

endmodule

// File: rtl/cam_pwr_seq.sv
// N-camera power-up sequencer: staggered PWDN/RESET release and ready flags.
// Optional feature macro: CAM_SLEEP_EN (adds sleep_req and SLEEP/WAKE states).
// Ports:
//   clk, rst_n : clock, async active-low reset (sequence starts on release)
//   restart    : one-cycle pulse, re-runs the full sequence
//   ch_en      : channel enable mask, latched at sequence start
//   sleep_req  : per-channel sleep request (CAM_SLEEP_EN only)
//   ov_pwdn    : per-camera power-down, 1 = powered down
//   ov_rst     : per-camera reset, 0 = held in reset
//   init_en    : per-camera ready / start-config flag
//   all_done   : every enabled channel ready (combinational)
module cam_pwr_seq
  import cam_pwr_pkg::*;
#(
  parameter int unsigned N_CAM      = DEF_N_CAM,
  parameter int unsigned TICK_CYC   = DEF_TICK_CYC,
  parameter int unsigned T_PWUP_MS  = DEF_T_PWUP_MS,
  parameter int unsigned T_RST_MS   = DEF_T_RST_MS,
  parameter int unsigned T_CFG_MS   = DEF_T_CFG_MS,
  parameter int unsigned STAGGER_MS = DEF_STAGGER_MS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic [N_CAM-1:0] ch_en,
`ifdef CAM_SLEEP_EN
  input  logic [N_CAM-1:0] sleep_req,
`endif
  output logic [N_CAM-1:0] ov_pwdn,
  output logic [N_CAM-1:0] ov_rst,
  output logic [N_CAM-1:0] init_en,
  output logic             all_done
);

  localparam int unsigned CW = cnt_width((N_CAM - 1) * STAGGER_MS, T_PWUP_MS, T_RST_MS, T_CFG_MS);
  localparam int unsigned PW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYC - 1);

  logic             start_q;
  logic             start_c;
  logic [N_CAM-1:0] en_q;
  logic [PW-1:0]    presc_q;
  logic [PW-1:0]    presc_d;
  logic             tick_c;
  logic             run_c;
  logic [N_CAM-1:0] busy_c;
  ch_state_e        st [N_CAM];

  // start_q marks the first cycle after reset release as a sequence start.
  assign start_c = start_q | restart;
  assign tick_c  = (presc_q == PRESC_LAST);

  // Prescaler runs while any channel is timing an interval; in the start cycle
  // after reset the channels are not loaded yet, so look at ch_en directly.
  always_comb begin
    busy_c = '0;
    for (int k = 0; k < N_CAM; k++) busy_c[k] = is_timed(st[k]);
    run_c   = start_q ? (ch_en != '0) : (busy_c != '0);
    presc_d = '0;
    if (!restart && run_c) presc_d = tick_c ? '0 : presc_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b1;
      en_q    <= '0;
      presc_q <= '0;
    end else begin
      start_q <= 1'b0;
      presc_q <= presc_d;
      if (start_c) en_q <= ch_en;
    end
  end

  for (genvar k = 0; k < N_CAM; k++) begin : g_ch
    logic [CW-1:0] start_ticks;
    assign start_ticks = CW'(k * STAGGER_MS);

    cam_pwr_ch #(
      .CW        (CW),
      .T_PWUP_MS (T_PWUP_MS),
      .T_RST_MS  (T_RST_MS),
      .T_CFG_MS  (T_CFG_MS)
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .tick_i        (tick_c),
      .start_i       (start_c),
      .en_i          (ch_en[k]),
      .start_ticks_i (start_ticks),
`ifdef CAM_SLEEP_EN
      .sleep_i       (sleep_req[k]),
`endif
      .pwdn_o        (ov_pwdn[k]),
      .rst_o         (ov_rst[k]),
      .init_en_o     (init_en[k]),
      .state_o       (st[k])
    );
  end

  // Masked channels are ignored; an empty mask never reports done.
  assign all_done = (en_q != '0) && (&(~en_q | init_en));

endmodule
